// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider_pkg: shared types and constants for the programmable clock divider.
//   state_t      - controller state (IDLE, RUN)
//   MODE_FREE    - free-running operation
//   MODE_ONESHOT - fixed-length burst operation
package prog_clock_divider_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if: control/strobe bundle of the programmable clock divider.
//   master: drives enable, clear, mode, start, divisor, burst_len; observes strobes and status
//   slave : the divider itself
interface prog_clock_divider_if #(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 4
);
    logic                 enable;
    logic                 clear;
    logic                 mode;
    logic                 start;
    logic [DIV_WIDTH-1:0] divisor;
    logic [CNT_WIDTH-1:0] burst_len;
    logic                 pulse;
    logic                 half_pulse;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] pulse_count;
    modport master (
        output enable, clear, mode, start, divisor, burst_len,
        input  pulse, half_pulse, busy, done, pulse_count
    );
    modport slave (
        input  enable, clear, mode, start, divisor, burst_len,
        output pulse, half_pulse, busy, done, pulse_count
    );
endinterface

// File: rtl/prog_clock_divider_period.sv
// div_period_counter: period counter with divisor latch, wrap and half-point detection.
//   clk, rst : clock, asynchronous active-high reset
//   load     : latch divisor and restart the period
//   clr      : restart the period, keep the latched divisor
//   adv      : enabled cycle, advance the counter
//   divisor  : requested period (0 treated as 1)
//   wrap     : this advancing cycle ends the period
//   half     : this advancing cycle is the mid-period point
module div_period_counter #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clr,
    input  logic                 adv,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 wrap,
    output logic                 half
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, n_in, last;
    always_comb begin
        n_in  = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
        last  = div_q - 1'b1;
        wrap  = adv && (cnt_q == last);
        half  = adv && (cnt_q == (last >> 1));
        cnt_d = (clr || load || wrap) ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
        // The divisor is only sampled at a period boundary so a change never truncates a period
        div_d = (load || wrap) ? n_in : div_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= DIV_WIDTH'(1);
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end
endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: programmable period/half-period strobe generator with free-run and burst modes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of prog_clock_divider_if (controls in, registered strobes/status out)
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    prog_clock_divider_if.slave  bus
);
    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [CNT_WIDTH-1:0] burst_q, burst_d, pulse_count_q, pulse_count_d;
    logic                 pulse_q, pulse_d, half_q, half_d, done_q, done_d;
    logic                 load, clr, adv, wrap, half, burst_end;
    div_period_counter #(.DIV_WIDTH(DIV_WIDTH)) u_period (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clr     (clr),
        .adv     (adv),
        .divisor (bus.divisor),
        .wrap    (wrap),
        .half    (half)
    );
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        burst_d       = burst_q;
        pulse_count_d = pulse_count_q;
        pulse_d       = 1'b0;
        half_d        = 1'b0;
        done_d        = 1'b0;
        load          = 1'b0;
        clr           = 1'b0;
        adv           = 1'b0;
        // The final burst pulse is visible this cycle: stop counting and retire the burst
        burst_end     = (state_q == RUN) && (mode_q == MODE_ONESHOT) && pulse_q && (pulse_count_q == burst_q);
        if (bus.clear) begin
            state_d       = IDLE;
            pulse_count_d = '0;
            clr           = 1'b1;
        end else if (state_q == IDLE) begin
            if (bus.mode == MODE_FREE || bus.start) begin
                state_d       = RUN;
                mode_d        = bus.mode;
                burst_d       = (bus.burst_len == '0) ? CNT_WIDTH'(1) : bus.burst_len;
                pulse_count_d = '0;
                load          = 1'b1;
            end
        end else if (burst_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            adv           = bus.enable;
            pulse_d       = wrap;
            half_d        = half;
            pulse_count_d = wrap ? pulse_count_q + 1'b1 : pulse_count_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= MODE_FREE;
            burst_q       <= CNT_WIDTH'(1);
            pulse_count_q <= '0;
            pulse_q       <= 1'b0;
            half_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            burst_q       <= burst_d;
            pulse_count_q <= pulse_count_d;
            pulse_q       <= pulse_d;
            half_q        <= half_d;
            done_q        <= done_d;
        end
    end
    assign bus.pulse       = pulse_q;
    assign bus.half_pulse  = half_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.pulse_count = pulse_count_q;
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed and random stimulus checked against a behavioural model.
module tb_prog_clock_divider;
    localparam int DW = 8;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    string ph = "reset";
    // reference model: period length, enabled cycles elapsed in the period, pulses so far
    bit m_run, m_os, ep, eh, ed;
    int m_n, m_el, m_cnt, m_burst;
    prog_clock_divider_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    prog_clock_divider #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s.%s: got %0d expected %0d at %0t", ph, tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_run = 0; m_os = 0; ep = 0; eh = 0; ed = 0;
        m_n = 1; m_el = 0; m_cnt = 0; m_burst = 1;
    endtask
    task automatic model_edge();
        int n_in = (bus.divisor == 0) ? 1 : int'(bus.divisor);
        if (bus.clear) begin
            m_run = 0; m_el = 0; m_cnt = 0; ep = 0; eh = 0; ed = 0;
        end else if (!m_run) begin
            ep = 0; eh = 0; ed = 0;
            if (bus.mode == 1'b0 || bus.start) begin
                m_run = 1; m_os = bus.mode; m_n = n_in; m_el = 0; m_cnt = 0;
                m_burst = (bus.burst_len == 0) ? 1 : int'(bus.burst_len);
            end
        end else if (m_os && ep && m_cnt == m_burst) begin
            m_run = 0; ep = 0; eh = 0; ed = 1;
        end else begin
            ed = 0;
            ep = bus.enable && (m_el == m_n - 1);
            eh = bus.enable && (m_el == (m_n - 1) / 2);
            if (bus.enable) begin
                m_el++;
                if (m_el == m_n) begin
                    m_el = 0; m_n = n_in; m_cnt = (m_cnt + 1) % (1 << CW);
                end
            end
        end
    endtask
    task automatic check_all();
        chk("pulse", 32'(bus.pulse), 32'(ep));
        chk("half_pulse", 32'(bus.half_pulse), 32'(eh));
        chk("busy", 32'(bus.busy), 32'(m_run));
        chk("done", 32'(bus.done), 32'(ed));
        chk("pulse_count", 32'(bus.pulse_count), 32'(m_cnt));
    endtask
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        check_all();
    endtask
    initial begin
        int np;
        bus.enable = 1'b1; bus.clear = 1'b0; bus.mode = 1'b0; bus.start = 1'b0;
        bus.divisor = 8'd8; bus.burst_len = 4'd0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        ph = "free8";
        repeat (40) step();
        ph = "div0";
        bus.divisor = 8'd0;
        repeat (14) step();
        ph = "div1";
        bus.divisor = 8'd1;
        repeat (8) step();
        ph = "div2";
        bus.divisor = 8'd2;
        repeat (10) step();
        ph = "oneshot";
        bus.mode = 1'b1; bus.clear = 1'b1;
        step();
        bus.clear = 1'b0; bus.start = 1'b1; bus.divisor = 8'd4; bus.burst_len = 4'd3;
        step();
        bus.start = 1'b0;
        np = 0;
        repeat (20) begin
            step();
            np += int'(bus.pulse);
        end
        chk("burst_pulses", 32'(np), 32'd3);
        chk("held_count", 32'(bus.pulse_count), 32'd3);
        ph = "enable";
        bus.mode = 1'b0; bus.divisor = 8'd5;
        for (int i = 0; i < 40; i++) begin
            bus.enable = (i % 7) < 4;
            step();
        end
        bus.enable = 1'b1;
        ph = "divchg";
        bus.divisor = 8'd8; bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        repeat (4) step();
        bus.divisor = 8'd3;
        repeat (20) step();
        ph = "clrstart";
        bus.mode = 1'b1; bus.clear = 1'b1;
        step();
        bus.clear = 1'b0; bus.start = 1'b1; bus.divisor = 8'd3; bus.burst_len = 4'd5;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        bus.clear = 1'b1; bus.start = 1'b1;
        step();
        bus.clear = 1'b0; bus.start = 1'b0;
        repeat (3) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        ph = "async_rst";
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        step();
        rst = 1'b0;
        ph = "random";
        bus.mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.enable = $urandom_range(0, 3) != 0;
            bus.clear = $urandom_range(0, 59) == 0;
            bus.start = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 15) == 0)
                bus.divisor = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) bus.burst_len = 4'($urandom_range(0, 15));
            step();
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
